// File: rtl/cordic_req_arbiter_if.sv
// Request, core and response signal bundle for the CORDIC request arbiter.
// The slave side is the arbiter; the master side drives requests and the core.
interface cordic_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_angle;
    logic              core_start;
    logic [W-1:0]      core_angle;
    logic              core_busy;
    logic [W-1:0]      core_x;
    logic [W-1:0]      core_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_x;
    logic [W-1:0]      rsp_y;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_angle, core_busy, core_x, core_y, rsp_ready,
        output req_ready, core_start, core_angle,
        output rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err
    );

    modport master (
        output req_valid, req_angle, core_busy, core_x, core_y, rsp_ready,
        input  req_ready, core_start, core_angle,
        input  rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err
    );
endinterface

// File: rtl/cordic_req_arbiter.sv
// Round-robin arbiter sharing one CORDIC core between NREQ requesters,
// one job in flight, with a busy-wait timeout that yields an error response.
module cordic_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    cordic_req_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        RUN,
        RESP
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] id_q;
    logic [IW-1:0] gnt_id;
    logic          gnt_any;
    logic [W-1:0]  angle_q;
    logic [W-1:0]  x_q;
    logic [W-1:0]  y_q;
    logic          err_q;
    logic [CW-1:0] tcnt;
    logic          tmo;
    int            k;

    assign tmo = (tcnt == CW'(TIMEOUT - 1));

    // First valid requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        k       = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!gnt_any && bus.req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_id  = IW'(k);
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (gnt_any) state_n = ISSUE;
            ISSUE:     state_n = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.core_busy) state_n = RUN;
                else if (tmo)      state_n = RESP;
            end
            RUN:       if (!bus.core_busy || tmo) state_n = RESP;
            RESP:      if (bus.rsp_ready) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id_q    <= '0;
            angle_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            tcnt    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && gnt_any) begin
                angle_q <= bus.req_angle[int'(gnt_id)*W +: W];
                id_q    <= gnt_id;
                rr_ptr  <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (state == ISSUE)
                tcnt <= '0;
            else if (state == WAIT_BUSY || state == RUN)
                tcnt <= tcnt + 1'b1;
            // A real busy fall wins over a timeout landing in the same cycle.
            if (state_n == RESP && state != RESP) begin
                if (state == RUN && !bus.core_busy) begin
                    x_q   <= bus.core_x;
                    y_q   <= bus.core_y;
                    err_q <= 1'b0;
                end else begin
                    x_q   <= '0;
                    y_q   <= '0;
                    err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && gnt_any) bus.req_ready[gnt_id] = 1'b1;
    end

    assign bus.core_start = (state == ISSUE);
    assign bus.core_angle = (state == ISSUE) ? angle_q : '0;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_x      = x_q;
    assign bus.rsp_y      = y_q;
    assign bus.rsp_err    = err_q;
endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter: reset, single job, round robin,
// wrap, timeout, response back-pressure and reset mid-job.
module tb_cordic_req_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cordic_req_arbiter_if #(.NREQ(4), .W(16)) bus ();

    cordic_req_arbiter #(.NREQ(4), .W(16), .TIMEOUT(64)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_angle = '0;
        bus.core_busy = 1'b0;
        bus.core_x    = '0;
        bus.core_y    = '0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // From the accept cycle, run the core for n busy cycles; ends in RESP.
    task automatic serve(input int n, input logic [15:0] x, input logic [15:0] y);
        tick();
        tick();
        bus.core_busy = 1'b1;
        repeat (n) tick();
        bus.core_busy = 1'b0;
        bus.core_x    = x;
        bus.core_y    = y;
        tick();
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
        checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", bus.core_start); end
        checks++; if (bus.core_angle !== 16'h0) begin errors++; $display("FAIL reset_angle got %h want 0000", bus.core_angle); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if ({bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_err} !== 35'h0) begin errors++; $display("FAIL reset_rsp got %h want 0", {bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_err}); end
    endtask

    task automatic test_basic();
        bus.req_valid = 4'b0001;
        bus.req_angle = 64'h0000_0000_0000_1234;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready got %b want 0001", bus.req_ready); end
        checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL basic_start_early got %b want 0", bus.core_start); end
        tick();
        bus.req_valid = 4'b0000;
        bus.core_busy = 1'b1;
        #1;
        checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL basic_start got %b want 1", bus.core_start); end
        checks++; if (bus.core_angle !== 16'h1234) begin errors++; $display("FAIL basic_angle got %h want 1234", bus.core_angle); end
        tick();
        checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL basic_start_len got %b want 0", bus.core_start); end
        repeat (30) tick();
        bus.core_busy = 1'b0;
        bus.core_x    = 16'h0100;
        bus.core_y    = 16'h0200;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_rsp_early got %b want 0", bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_rsp_valid got %b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL basic_rsp_id got %0d want 0", bus.rsp_id); end
        checks++; if (bus.rsp_x !== 16'h0100) begin errors++; $display("FAIL basic_rsp_x got %h want 0100", bus.rsp_x); end
        checks++; if (bus.rsp_y !== 16'h0200) begin errors++; $display("FAIL basic_rsp_y got %h want 0200", bus.rsp_y); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL basic_rsp_err got %b want 0", bus.rsp_err); end
        ack();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_angle = 64'h4444_3333_2222_1111;
        for (int j = 0; j < 5; j++) begin
            exp_rdy = 4'b0001 << (j % 4);
            #1;
            checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready job %0d got %b want %b", j, bus.req_ready, exp_rdy); end
            serve(3, 16'h1000 + 16'(j), 16'h2000 + 16'(j));
            checks++; if (bus.rsp_id !== 2'(j % 4)) begin errors++; $display("FAIL rr_rsp_id job %0d got %0d want %0d", j, bus.rsp_id, j % 4); end
            checks++; if (bus.rsp_x !== 16'h1000 + 16'(j)) begin errors++; $display("FAIL rr_rsp_x job %0d got %h want %h", j, bus.rsp_x, 16'h1000 + 16'(j)); end
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rr_ready_resp job %0d got %b want 0000", j, bus.req_ready); end
            ack();
        end
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req_angle = 64'h4444_3333_2222_1111;
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_setup got %b want 0010", bus.req_ready); end
        serve(1, 16'h0001, 16'h0002);
        ack();
        bus.req_valid = 4'b0011;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant got %b want 0001", bus.req_ready); end
        serve(1, 16'h0003, 16'h0004);
        ack();
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ptr got %b want 0010", bus.req_ready); end
        serve(1, 16'h0005, 16'h0006);
        ack();
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int lat;
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL tmo_ready got %b want 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL tmo_start got %b want 1", bus.core_start); end
        lat = 0;
        while (!bus.rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 65) begin errors++; $display("FAIL tmo_latency got %0d want 65", lat); end
        checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", bus.rsp_err); end
        checks++; if ({bus.rsp_x, bus.rsp_y} !== 32'h0) begin errors++; $display("FAIL tmo_xy got %h want 0", {bus.rsp_x, bus.rsp_y}); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL tmo_id got %0d want 0", bus.rsp_id); end
        ack();
    endtask

    task automatic test_resp_hold();
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL hold_grant got %b want 0010", bus.req_ready); end
        serve(5, 16'hABCD, 16'h1357);
        for (int c = 0; c < 10; c++) begin
            checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_err} !== {1'b1, 2'd1, 16'hABCD, 16'h1357, 1'b0}) begin errors++; $display("FAIL hold_rsp cycle %0d got %h want %h", c, {bus.rsp_valid, bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_err}, {1'b1, 2'd1, 16'hABCD, 16'h1357, 1'b0}); end
            checks++; if ({bus.req_ready, bus.core_start} !== 5'b0) begin errors++; $display("FAIL hold_quiet cycle %0d got %b want 00000", c, {bus.req_ready, bus.core_start}); end
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL hold_hs_ready got %b want 0000", bus.req_ready); end
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL hold_next_ready got %b want 0100", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_rsp_drop got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_reset_midjob();
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL mid_start got %b want 1", bus.core_start); end
        checks++; if (bus.core_angle !== 16'h3333) begin errors++; $display("FAIL mid_angle got %h want 3333", bus.core_angle); end
        tick();
        bus.core_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        #1;
        checks++; if ({bus.req_ready, bus.core_start, bus.core_angle} !== 21'h0) begin errors++; $display("FAIL mid_rst_core got %h want 0", {bus.req_ready, bus.core_start, bus.core_angle}); end
        checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_err} !== 36'h0) begin errors++; $display("FAIL mid_rst_rsp got %h want 0", {bus.rsp_valid, bus.rsp_id, bus.rsp_x, bus.rsp_y, bus.rsp_err}); end
        rst = 1'b0;
        bus.core_busy = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant got %b want 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.core_angle !== 16'h1111) begin errors++; $display("FAIL mid_regrant_angle got %h want 1111", bus.core_angle); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_resp_hold();
        test_reset_midjob();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
